exu_cal: RTL and testbench
==========================

# exu_cal

Shared calculation center of the cirno9 execute stage, directly downstream of the ALU front end. It receives one-hot operation bits and two 33-bit pre-extended operands over a val/rdy handshake, and returns a 32-bit result. ADD, SUB, XOR and CMP complete combinationally in the request cycle. SLL, SRL and SRA run on an iterative shifter that holds off the requester until the result is ready.

## Interface
Parameters:
- SHIFT_STEP, 4: maximum bits shifted per cycle; power of two, 1..16.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- hs_al4cal_val  in  1  request valid; the requester holds it and i_cal_opb stable until rdy.
- hs_cal4al_rdy  out  1  completion strobe. o_cal_res is valid and the request is consumed in any cycle where val and rdy are both high.
- i_cal_opb  in  `CIRNO_CAL_OPB_SIZE  op bits ADD, SUB, SLL, SRL, SRA, XOR, CMP, plus fields OPN1[32:0] and OPN2[32:0]. Operands arrive sign- or zero-extended by the requester.
- o_cal_res  out  32  result; 0 whenever rdy is low.
- o_cal_busy  out  1  registered; high while the shifter is in SHIFT or DONE.

## Operation
- Op decode priority when more than one bit is set: ADD > SUB > XOR > CMP > SLL > SRL > SRA. No op bit set with val high: rdy=1, result 0.
- ADD: (opn1+opn2)[31:0]. SUB: (opn1−opn2)[31:0]. XOR: opn1[31:0]^opn2[31:0].
- CMP: 33-bit diff = opn1−opn2; result = {31'b0, diff[32]}.
  - Signed or unsigned compare follows the operand extension; the block has no op-specific handling.
- Shifts:
  - shamt = opn2[4:0].
  - The 33-bit accumulator loads opn1.
  - Right shifts fill from acc[32], which gives SRA with sign extension and SRL with zero fill, since the requester zero-extends for SRL.
  - SLL fills with 0.
  - Result = acc[31:0].
- FSM states IDLE, SHIFT, DONE:
  - IDLE, val, single-cycle op: rdy=1 combinationally; stay IDLE.
  - IDLE, val, shift op: load acc=opn1, cnt=shamt, latch the op; rdy=0; go to SHIFT.
  - SHIFT: step = min(cnt, SHIFT_STEP); shift acc by step; cnt -= step. If the entry cnt ≤ SHIFT_STEP, go to DONE.
  - DONE: rdy=1, o_cal_res=acc[31:0]; go to IDLE.
- Abort: val low in SHIFT or DONE returns the FSM to IDLE next cycle with no rdy. A flush therefore needs no extra port.

## Timing
- Single-cycle ops: latency 0; rdy is in the request cycle.
- Shift accepted in cycle 0: rdy in cycle 1 + max(1, ceil(shamt/SHIFT_STEP)).
  - shamt=0 gives cycle 2.
  - shamt=31 with SHIFT_STEP=4 gives cycle 9.
- Back-to-back requests:
  - A new request may present in the cycle after DONE.
  - A single-cycle op following a shift completes in that cycle.
- Reset values: state IDLE, acc 0, cnt 0, o_cal_busy 0.
  - While rst is high, rdy=0 and o_cal_res=0 regardless of val.
- Reset mid-operation: the FSM returns to IDLE the next cycle; no rdy for the aborted op.
- rdy depends combinationally on val and the op bits in IDLE. No combinational path runs from rdy back to val.

## Structure
- Op bit indices and the OPN1/OPN2 field ranges live in cirno9_define.v, alongside CIRNO_CAL_OPB_SIZE. Add CIRNO_CAL_ST_IDLE/SHIFT/DONE state encodings there.
- One sub-module, exu_cal_shf, contains:
  - the acc/cnt registers;
  - the SHIFT_STEP-wide barrel stage;
  - DONE detection.
- The exu_cal top contains the decode, the adder/XOR/CMP datapath and the result mux.

## Test plan
- ADD opn1=0x0_7FFFFFFF, opn2=0x0_00000001 → rdy=1 in the same cycle, res=0x80000000.
- CMP signed opn1=0x1_FFFFFFFF (−1), opn2=0x0_00000001 → res=1. CMP zero-extended opn1=0x0_FFFFFFFF, opn2=0x0_00000001 → res=0.
- SRA opn1=0x1_80000000, shamt=31, SHIFT_STEP=4:
  - rdy low in cycles 0–8, high in cycle 9, res=0xFFFFFFFF;
  - o_cal_busy high in cycles 1–9.
- SLL opn1=0x0_12345678, shamt=0 → rdy in cycle 2, res=0x12345678. The same op with shamt=4 → rdy in cycle 2, res=0x23456780.
- SRL by 20, val dropped in cycle 3 → no rdy, IDLE in cycle 4. An ADD 2+3 presented in cycle 4 → rdy in cycle 4, res=5.
- rst pulsed in cycle 2 of a shift by 16 → rdy=0 and res=0 during reset, o_cal_busy=0 the next cycle, and no stale rdy afterwards.

Source files
------------

// File: rtl/exu_cal_pkg.sv
// Shared definitions for the cirno9 execute-stage calculation center:
// op-bit layout of the request bundle, operand fields and shifter state encodings.
package exu_cal_pkg;

    localparam int CIRNO_CAL_OP_ADD   = 0;
    localparam int CIRNO_CAL_OP_SUB   = 1;
    localparam int CIRNO_CAL_OP_SLL   = 2;
    localparam int CIRNO_CAL_OP_SRL   = 3;
    localparam int CIRNO_CAL_OP_SRA   = 4;
    localparam int CIRNO_CAL_OP_XOR   = 5;
    localparam int CIRNO_CAL_OP_CMP   = 6;

    localparam int CIRNO_CAL_OPN_W    = 33;
    localparam int CIRNO_CAL_OPN1_LSB = 7;
    localparam int CIRNO_CAL_OPN2_LSB = CIRNO_CAL_OPN1_LSB + CIRNO_CAL_OPN_W;
    localparam int CIRNO_CAL_OPB_SIZE = CIRNO_CAL_OPN2_LSB + CIRNO_CAL_OPN_W;

    typedef enum logic [1:0] {
        CIRNO_CAL_ST_IDLE  = 2'd0,
        CIRNO_CAL_ST_SHIFT = 2'd1,
        CIRNO_CAL_ST_DONE  = 2'd2
    } cal_st_e;

    function automatic logic [4:0] shf_step(input logic [4:0] cnt, input logic [4:0] max_step);
        return (cnt > max_step) ? max_step : cnt;
    endfunction

endpackage

// File: rtl/exu_cal_shf.sv
// Iterative shifter for exu_cal: holds acc/cnt, applies up to SHIFT_STEP bits per
// cycle and flags DONE; a dropped val while busy abandons the operation.
module exu_cal_shf
    import exu_cal_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        val,
    input  logic        start,
    input  logic        left,
    input  logic [32:0] opn1,
    input  logic [4:0]  shamt,
    output logic        done,
    output logic        busy,
    output logic [31:0] res
);

    localparam logic [4:0] STEP_MAX = 5'(SHIFT_STEP);

    cal_st_e     state_q, state_d;
    logic [32:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        busy_q, busy_d;
    logic [4:0]  step;
    logic [32:0] acc_shl, acc_shr;

    // Right shifts replicate acc[32]; the requester's operand extension picks SRA vs SRL.
    always_comb begin
        step    = shf_step(cnt_q, STEP_MAX);
        acc_shl = acc_q << step;
        acc_shr = $signed(acc_q) >>> step;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        case (state_q)
            CIRNO_CAL_ST_IDLE: begin
                if (start) begin
                    acc_d   = opn1;
                    cnt_d   = shamt;
                    left_d  = left;
                    state_d = CIRNO_CAL_ST_SHIFT;
                end
            end
            CIRNO_CAL_ST_SHIFT: begin
                if (!val) begin
                    state_d = CIRNO_CAL_ST_IDLE;
                end else begin
                    acc_d = left_q ? acc_shl : acc_shr;
                    cnt_d = cnt_q - step;
                    if (cnt_q <= STEP_MAX) state_d = CIRNO_CAL_ST_DONE;
                end
            end
            CIRNO_CAL_ST_DONE: state_d = CIRNO_CAL_ST_IDLE;
            default:           state_d = CIRNO_CAL_ST_IDLE;
        endcase
        busy_d = (state_d != CIRNO_CAL_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CIRNO_CAL_ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            busy_q  <= busy_d;
        end
    end

    assign done = (state_q == CIRNO_CAL_ST_DONE);
    assign busy = busy_q;
    assign res  = acc_q[31:0];

endmodule

// File: rtl/exu_cal.sv
// cirno9 execute-stage calculation center: single-cycle ADD/SUB/XOR/CMP datapath
// plus an iterative shifter, all behind one val/rdy handshake.
module exu_cal
    import exu_cal_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hs_al4cal_val,
    output logic                          hs_cal4al_rdy,
    input  logic [CIRNO_CAL_OPB_SIZE-1:0] i_cal_opb,
    output logic [31:0]                   o_cal_res,
    output logic                          o_cal_busy
);

    logic [32:0] opn1, opn2, diff;
    logic        op_add, op_sub, op_sll, op_srl, op_sra, op_xor, op_cmp;
    logic        single_op, shift_req, shf_start, shf_done, shf_busy;
    logic [31:0] single_res, shf_res;

    assign opn1   = i_cal_opb[CIRNO_CAL_OPN1_LSB +: CIRNO_CAL_OPN_W];
    assign opn2   = i_cal_opb[CIRNO_CAL_OPN2_LSB +: CIRNO_CAL_OPN_W];
    assign op_add = i_cal_opb[CIRNO_CAL_OP_ADD];
    assign op_sub = i_cal_opb[CIRNO_CAL_OP_SUB];
    assign op_sll = i_cal_opb[CIRNO_CAL_OP_SLL];
    assign op_srl = i_cal_opb[CIRNO_CAL_OP_SRL];
    assign op_sra = i_cal_opb[CIRNO_CAL_OP_SRA];
    assign op_xor = i_cal_opb[CIRNO_CAL_OP_XOR];
    assign op_cmp = i_cal_opb[CIRNO_CAL_OP_CMP];

    // CMP takes the sign of the 33-bit difference, so operand extension chooses signedness.
    always_comb begin
        diff       = opn1 - opn2;
        single_op  = op_add | op_sub | op_xor | op_cmp;
        shift_req  = !single_op && (op_sll || op_srl || op_sra);
        single_res = '0;
        if (op_add)      single_res = opn1[31:0] + opn2[31:0];
        else if (op_sub) single_res = diff[31:0];
        else if (op_xor) single_res = opn1[31:0] ^ opn2[31:0];
        else if (op_cmp) single_res = {31'b0, diff[32]};
    end

    assign shf_start = hs_al4cal_val && shift_req && !shf_busy && !rst;

    exu_cal_shf #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shf (
        .clk   (clk),
        .rst   (rst),
        .val   (hs_al4cal_val),
        .start (shf_start),
        .left  (op_sll),
        .opn1  (opn1),
        .shamt (opn2[4:0]),
        .done  (shf_done),
        .busy  (shf_busy),
        .res   (shf_res)
    );

    always_comb begin
        hs_cal4al_rdy = 1'b0;
        o_cal_res     = '0;
        if (!rst) begin
            if (shf_done)      hs_cal4al_rdy = hs_al4cal_val;
            else if (!shf_busy) hs_cal4al_rdy = hs_al4cal_val && !shift_req;
        end
        if (hs_cal4al_rdy) o_cal_res = shf_done ? shf_res : single_res;
    end

    assign o_cal_busy = shf_busy;

endmodule

// File: tb/tb_exu_cal.sv
// Directed bench for exu_cal: expected results with their completion cycle go into
// a queue at issue time; a negedge monitor pops and checks on every rdy.
module tb_exu_cal;
    import exu_cal_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          val;
    logic                          rdy;
    logic [CIRNO_CAL_OPB_SIZE-1:0] opb;
    logic [31:0]                   res;
    logic                          busy;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    localparam logic [6:0] ADD = 7'b0000001;
    localparam logic [6:0] SUB = 7'b0000010;
    localparam logic [6:0] SLL = 7'b0000100;
    localparam logic [6:0] SRL = 7'b0001000;
    localparam logic [6:0] SRA = 7'b0010000;
    localparam logic [6:0] XOR = 7'b0100000;
    localparam logic [6:0] CMP = 7'b1000000;

    exu_cal #(.SHIFT_STEP(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .hs_al4cal_val (val),
        .hs_cal4al_rdy (rdy),
        .i_cal_opb     (opb),
        .o_cal_res     (res),
        .o_cal_busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [CIRNO_CAL_OPB_SIZE-1:0] mk(input logic [6:0] ops,
                                                         input logic [32:0] a,
                                                         input logic [32:0] b);
        logic [CIRNO_CAL_OPB_SIZE-1:0] v;
        v = '0;
        v[6:0] = ops;
        v[CIRNO_CAL_OPN1_LSB +: CIRNO_CAL_OPN_W] = a;
        v[CIRNO_CAL_OPN2_LSB +: CIRNO_CAL_OPN_W] = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_res(input string name, input logic [31:0] r, input int at);
        exp_t e;
        e.res  = r;
        e.cyc  = at;
        e.name = name;
        sb.push_back(e);
    endtask

    // Single-cycle request: presented for one cycle, completes in that same cycle.
    task automatic single(input string name, input logic [6:0] ops, input logic [32:0] a,
                          input logic [32:0] b, input logic [31:0] r);
        val = 1'b1;
        opb = mk(ops, a, b);
        expect_res(name, r, cyc);
        step();
        val = 1'b0;
        opb = '0;
    endtask

    // Shift request held until the expected completion cycle, then released.
    task automatic shift(input string name, input logic [6:0] ops, input logic [32:0] a,
                         input logic [4:0] sh, input logic [31:0] r, input int lat);
        int t0;
        t0  = cyc;
        val = 1'b1;
        opb = mk(ops, a, {28'b0, sh});
        expect_res(name, r, t0 + lat);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check({name, "_busy"}, {31'b0, busy}, {31'b0, (k >= 1)});
            step();
        end
        val = 1'b0;
        opb = '0;
    endtask

    always @(negedge clk) begin
        if (rdy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rdy: got rdy=1 res=0x%08h expected no rdy (cycle %0d)", res, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, res, e.res);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int t0;
        rst = 1'b1;
        val = 1'b1;
        opb = mk(ADD, 33'h0_00000002, 33'h0_00000003);
        @(negedge clk);
        check("reset_rdy", {31'b0, rdy}, 32'd0);
        check("reset_res", res, 32'd0);
        step();
        rst = 1'b0;
        val = 1'b0;
        opb = '0;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        step();

        single("add_ovf", ADD, 33'h0_7FFFFFFF, 33'h0_00000001, 32'h80000000);
        single("sub_neg", SUB, 33'h0_00000005, 33'h0_00000007, 32'hFFFFFFFE);
        single("xor", XOR, 33'h0_FFFF0000, 33'h0_0F0F0F0F, 32'hF0F00F0F);
        single("cmp_signed", CMP, 33'h1_FFFFFFFF, 33'h0_00000001, 32'd1);
        single("cmp_unsigned", CMP, 33'h0_FFFFFFFF, 33'h0_00000001, 32'd0);
        single("prio_add", ADD | SUB | SLL, 33'h0_00000001, 33'h0_00000002, 32'd3);
        single("prio_cmp_over_sra", CMP | SRA, 33'h0_00000001, 33'h0_00000002, 32'd1);
        single("no_op", 7'b0, 33'h0_12345678, 33'h0_00000001, 32'd0);

        shift("sra31", SRA, 33'h1_80000000, 5'd31, 32'hFFFFFFFF, 9);
        @(negedge clk);
        check("sra31_busy_after", {31'b0, busy}, 32'd0);
        step();

        shift("sll0", SLL, 33'h0_12345678, 5'd0, 32'h12345678, 2);
        shift("sll4", SLL, 33'h0_12345678, 5'd4, 32'h23456780, 2);
        single("add_after_shift", ADD, 33'h0_00000010, 33'h0_00000001, 32'h00000011);
        shift("srl4", SRL, 33'h0_80000000, 5'd4, 32'h08000000, 2);
        shift("sra5", SRA, 33'h1_F0000000, 5'd5, 32'hFF800000, 3);

        // SRL by 20 abandoned when val drops in cycle 3; ADD in cycle 4 completes at once.
        t0  = cyc;
        val = 1'b1;
        opb = mk(SRL, 33'h0_FFFFFFFF, 33'd20);
        step(); step(); step();
        val = 1'b0;
        opb = '0;
        step();
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_cycle", 32'(cyc - t0), 32'd4);
        single("add_after_abort", ADD, 33'h0_00000002, 33'h0_00000003, 32'd5);

        // Reset in cycle 2 of a shift by 16.
        val = 1'b1;
        opb = mk(SLL, 33'h0_00000001, 33'd16);
        step(); step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rdy", {31'b0, rdy}, 32'd0);
        check("midrst_res", res, 32'd0);
        step();
        rst = 1'b0;
        val = 1'b0;
        opb = '0;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 6; k++) step();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_rdy: got %0d outstanding results expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
